// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a flop-based on-chip SRAM with byte/half/word
// access, configurable OKAY wait states and a two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [31:0]           haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic [1:0]            hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);

    localparam int         WORDS     = 2 ** (ADDR_WIDTH - 2);
    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    logic [1:0]            state;
    logic [2:0]            wait_cnt;
    logic                  dp_valid;
    logic                  dp_write;
    logic [ADDR_WIDTH-1:0] dp_addr;
    logic [1:0]            dp_size;
    logic [ADDR_WIDTH-3:0] dp_word;
    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic                  accept;
    logic                  illegal;
    logic                  commit;
    logic [3:0]            lane_en;
    logic                  unused_ok;

    assign unused_ok = ^{hburst, hprot, htrans[0]};

    assign hreadyout = (state == ST_IDLE) || (state == ST_ERR2);
    assign hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;
    assign accept    = hsel & hready & htrans[1] & hreadyout;
    assign dp_word   = dp_addr[ADDR_WIDTH-1:2];
    assign commit    = dp_valid & dp_write & hreadyout;
    assign hrdata    = (dp_valid & ~dp_write & hreadyout) ? mem[dp_word] : '0;

    // Anything outside the decoded window or misaligned for its size is refused.
    always_comb begin
        illegal = (haddr >> ADDR_WIDTH) != 32'd0;
        case (hsize)
            3'd0:    ;
            3'd1:    if (haddr[0]) illegal = 1'b1;
            3'd2:    if (haddr[1:0] != 2'b00) illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (dp_size)
            2'd0:    lane_en = 4'b0001 << dp_addr[1:0];
            2'd1:    lane_en = dp_addr[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= ST_IDLE;
            wait_cnt <= 3'd0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            dp_size  <= 2'd0;
        end else begin
            case (state)
                ST_IDLE, ST_ERR2: begin
                    dp_valid <= accept & ~illegal;
                    if (accept) begin
                        dp_write <= hwrite;
                        dp_addr  <= haddr[ADDR_WIDTH-1:0];
                        dp_size  <= hsize[1:0];
                        if (illegal) begin
                            state <= ST_ERR1;
                        end else if (WAIT_LOAD != 3'd0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) state <= ST_IDLE;
                end
                ST_ERR1: state <= ST_ERR2;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Write data arrives in the data phase, so lanes commit on the edge that ends it.
    always_ff @(posedge hclk) begin
        for (int i = 0; i < 4; i++) begin
            if (commit && lane_en[i]) mem[dp_word][8*i +: 8] <= hwdata[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: one zero-wait and one three-wait
// instance share the bus, the driver pushes expected responses, a monitor checks them.
module tb_ahb_sram_slave;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        use_w;

    logic        hsel0, hselw, hro0, hrow, hready, hreadyout;
    logic [1:0]  hresp0, hrespw, hresp;
    logic [31:0] hrdata0, hrdataw, hrdata;

    assign hsel0     = hsel & ~use_w;
    assign hselw     = hsel & use_w;
    assign hreadyout = use_w ? hrow : hro0;
    assign hresp     = use_w ? hrespw : hresp0;
    assign hrdata    = use_w ? hrdataw : hrdata0;
    assign hready    = hreadyout;

    ahb_sram_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hready(hready), .hreadyout(hro0), .hresp(hresp0), .hrdata(hrdata0));

    ahb_sram_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_STATES(3)) dutw (
        .hclk(hclk), .hresetn(hresetn), .hsel(hselw), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hready(hready), .hreadyout(hrow), .hresp(hrespw), .hrdata(hrdataw));

    always #5 hclk = ~hclk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          waits;
    } exp_t;

    exp_t        exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_acc_cyc = 0;
    int          done_cyc = 0;
    logic [31:0] prev_wdata = 32'd0;

    always @(posedge hclk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: tracks the data phase and pops one expectation when it completes.
    logic pending = 1'b0;
    int   waits = 0;
    always @(negedge hclk) begin
        if (!hresetn) begin
            pending = 1'b0;
            waits   = 0;
        end else begin
            if (pending) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_phase: got a data phase expected none");
                    pending = 1'b0;
                end else if (hreadyout) begin
                    checkOutput({name_q[0], "_resp"}, {30'd0, hresp}, {30'd0, exp_q[0].resp});
                    checkOutput({name_q[0], "_rdata"}, hrdata, exp_q[0].data);
                    checkOutput({name_q[0], "_waits"}, waits, exp_q[0].waits);
                    void'(exp_q.pop_front());
                    void'(name_q.pop_front());
                    done_cyc = cyc;
                    pending  = 1'b0;
                end else begin
                    waits++;
                    checkOutput({name_q[0], "_wresp"}, {30'd0, hresp}, {30'd0, exp_q[0].resp});
                end
            end else begin
                checkOutput("idle_ready", {31'd0, hreadyout}, 32'd1);
                checkOutput("idle_resp", {30'd0, hresp}, 32'd0);
                checkOutput("idle_rdata", hrdata, 32'd0);
            end
            if (hsel && hready && htrans[1]) begin
                pending = 1'b1;
                waits   = 0;
            end
        end
    end

    task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic wr,
                                 input logic [2:0] size, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic push,
                                 input logic [31:0] exp_data, input logic [1:0] exp_resp,
                                 input int exp_waits, input string name);
        int n;
        hsel   = sel;
        htrans = trans;
        hwrite = wr;
        hsize  = size;
        haddr  = addr;
        hwdata = prev_wdata;
        if (push) begin
            exp_q.push_back('{data: exp_data, resp: exp_resp, waits: exp_waits});
            name_q.push_back(name);
        end
        n = 0;
        @(negedge hclk);
        while (!hready && n < 50) begin
            n++;
            @(negedge hclk);
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got hready low for %0d cycles expected at most 50", name, n);
        end
        @(posedge hclk);
        #1;
        last_acc_cyc = cyc;
        prev_wdata   = wdata;
    endtask

    task automatic idleBeat();
        applyStimulus(1'b0, 2'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0, 2'b00, 0, "idle");
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            idleBeat();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d outstanding expected 0", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
        idleBeat();
    endtask

    task automatic resetPulse(input string name);
        #1 hresetn = 1'b0;
        #1;
        checkOutput({name, "_ready"}, {31'd0, hreadyout}, 32'd1);
        checkOutput({name, "_resp"}, {30'd0, hresp}, 32'd0);
        checkOutput({name, "_rdata"}, hrdata, 32'd0);
        hsel   = 1'b0;
        htrans = 2'd0;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        hresetn = 1'b0; use_w = 1'b0; hsel = 1'b0; haddr = 32'd0; htrans = 2'd0;
        hwrite = 1'b0; hsize = 3'd0; hburst = 3'd0; hprot = 4'b0011; hwdata = 32'd0;
        repeat (3) @(posedge hclk);
        #1;
        checkOutput("rst0_ready", {31'd0, hro0}, 32'd1);
        checkOutput("rst0_resp", {30'd0, hresp0}, 32'd0);
        checkOutput("rstw_ready", {31'd0, hrow}, 32'd1);
        checkOutput("rstw_rdata", hrdataw, 32'd0);
        @(negedge hclk);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;

        // Zero-wait slave: basic, lanes, back-to-back, idle/busy, errors.
        applyStimulus(1, 2'd2, 1, 3'd2, 32'h10, 32'hDEADBEEF, 1, 32'h0, 2'b00, 0, "wr10");
        applyStimulus(1, 2'd2, 0, 3'd2, 32'h10, 32'h0, 1, 32'hDEADBEEF, 2'b00, 0, "rd10");
        applyStimulus(1, 2'd2, 1, 3'd2, 32'h20, 32'h0, 1, 32'h0, 2'b00, 0, "wr20");
        applyStimulus(1, 2'd2, 1, 3'd0, 32'h21, 32'h0000AA00, 1, 32'h0, 2'b00, 0, "wrb21");
        applyStimulus(1, 2'd2, 1, 3'd1, 32'h22, 32'h12340000, 1, 32'h0, 2'b00, 0, "wrh22");
        applyStimulus(1, 2'd2, 0, 3'd2, 32'h20, 32'h0, 1, 32'h1234AA00, 2'b00, 0, "rd20");
        applyStimulus(1, 2'd2, 1, 3'd2, 32'h40, 32'h00000055, 1, 32'h0, 2'b00, 0, "wr40");
        applyStimulus(1, 2'd2, 0, 3'd2, 32'h40, 32'h0, 1, 32'h00000055, 2'b00, 0, "rd40");
        applyStimulus(1, 2'd0, 0, 3'd2, 32'h40, 32'h0, 0, 32'h0, 2'b00, 0, "idle_t");
        applyStimulus(1, 2'd1, 0, 3'd2, 32'h40, 32'h0, 0, 32'h0, 2'b00, 0, "busy_t");
        applyStimulus(0, 2'd2, 1, 3'd2, 32'h10, 32'hFFFFFFFF, 0, 32'h0, 2'b00, 0, "unsel");
        applyStimulus(1, 2'd2, 0, 3'd2, 32'h02, 32'h0, 1, 32'h0, 2'b01, 1, "err_mis");
        applyStimulus(1, 2'd2, 1, 3'd3, 32'h10, 32'hFFFFFFFF, 1, 32'h0, 2'b01, 1, "err_sz3");
        applyStimulus(1, 2'd2, 1, 3'd2, 32'h0001_0010, 32'h11111111, 1, 32'h0, 2'b01, 1, "err_rng");
        applyStimulus(1, 2'd2, 1, 3'd1, 32'h21, 32'hFFFFFFFF, 1, 32'h0, 2'b01, 1, "err_half");
        applyStimulus(1, 2'd2, 0, 3'd2, 32'h10, 32'h0, 1, 32'hDEADBEEF, 2'b00, 0, "rd10_kept");
        applyStimulus(1, 2'd2, 0, 3'd2, 32'h20, 32'h0, 1, 32'h1234AA00, 2'b00, 0, "rd20_kept");
        drain();

        // Three-wait slave: single transfers, INCR4 bursts, error, resets.
        use_w  = 1'b1;
        hburst = 3'd0;
        applyStimulus(1, 2'd2, 1, 3'd2, 32'h100, 32'hCAFEF00D, 1, 32'h0, 2'b00, 3, "w_wr100");
        applyStimulus(1, 2'd2, 0, 3'd2, 32'h100, 32'h0, 1, 32'hCAFEF00D, 2'b00, 3, "w_rd100");
        hburst = 3'd3;
        applyStimulus(1, 2'd2, 1, 3'd2, 32'h200, 32'h11111111, 1, 32'h0, 2'b00, 3, "bw0");
        applyStimulus(1, 2'd3, 1, 3'd2, 32'h204, 32'h22222222, 1, 32'h0, 2'b00, 3, "bw1");
        applyStimulus(1, 2'd3, 1, 3'd2, 32'h208, 32'h33333333, 1, 32'h0, 2'b00, 3, "bw2");
        applyStimulus(1, 2'd3, 1, 3'd2, 32'h20C, 32'h44444444, 1, 32'h0, 2'b00, 3, "bw3");
        applyStimulus(1, 2'd2, 0, 3'd2, 32'h200, 32'h0, 1, 32'h11111111, 2'b00, 3, "br0");
        begin
            int burst_start;
            burst_start = last_acc_cyc;
            applyStimulus(1, 2'd3, 0, 3'd2, 32'h204, 32'h0, 1, 32'h22222222, 2'b00, 3, "br1");
            applyStimulus(1, 2'd3, 0, 3'd2, 32'h208, 32'h0, 1, 32'h33333333, 2'b00, 3, "br2");
            applyStimulus(1, 2'd3, 0, 3'd2, 32'h20C, 32'h0, 1, 32'h44444444, 2'b00, 3, "br3");
            hburst = 3'd0;
            drain();
            checkOutput("burst_cycles", done_cyc - burst_start + 1, 32'd16);
        end
        applyStimulus(1, 2'd2, 0, 3'd3, 32'h100, 32'h0, 1, 32'h0, 2'b01, 1, "w_err_sz3");
        drain();

        applyStimulus(1, 2'd2, 1, 3'd2, 32'h100, 32'hBADBAD00, 0, 32'h0, 2'b00, 3, "w_wr_abort");
        hwdata = 32'hBADBAD00;
        resetPulse("rst_wait");
        applyStimulus(1, 2'd2, 0, 3'd2, 32'h100, 32'h0, 1, 32'hCAFEF00D, 2'b00, 3, "w_rd_after_rst");
        drain();

        applyStimulus(1, 2'd2, 0, 3'd3, 32'h100, 32'h0, 0, 32'h0, 2'b01, 1, "w_err_abort");
        resetPulse("rst_err1");
        applyStimulus(1, 2'd2, 0, 3'd2, 32'h204, 32'h0, 1, 32'h22222222, 2'b00, 3, "w_rd_after_err");
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
